// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if: command, response and APB3 requester signal bundle
//   master modport: view of apb_master_ctrl (drives CMD_READY, RSP_*, ERR_COUNT, APB request signals)
//   slave modport:  view of the command source / response sink / APB completer side
interface apb_master_ctrl_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ERRCNT_W = 8
);
    logic                CMD_VALID;
    logic                CMD_READY;
    logic                CMD_WRITE;
    logic [ADDR_W-1:0]   CMD_ADDR;
    logic [DATA_W-1:0]   CMD_WDATA;
    logic                RSP_VALID;
    logic                RSP_READY;
    logic [DATA_W-1:0]   RSP_RDATA;
    logic                RSP_ERR;
    logic                RSP_TIMEOUT;
    logic [ERRCNT_W-1:0] ERR_COUNT;
    logic                PSELx;
    logic                PENABLE;
    logic                PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W-1:0]   PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT, ERR_COUNT,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT, ERR_COUNT,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB3 requester turning single-word commands into SETUP/ACCESS transfers
//   PCLK    clock, all state on rising edge
//   PRESETn asynchronous active-low reset
//   bus     command channel, response channel (data/err/timeout), ERR_COUNT and APB3 request signals
module apb_master_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERRCNT_W       = 8
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    apb_master_ctrl_if.master  bus
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       wait_cnt, wait_cnt_n;
    logic                psel_n, penable_n, pwrite_n;
    logic [ADDR_W-1:0]   paddr_n;
    logic [DATA_W-1:0]   pwdata_n, rsp_rdata_n;
    logic                rsp_valid_n, rsp_err_n, rsp_timeout_n;
    logic [ERRCNT_W-1:0] err_count_n;
    logic                err_hit, expire;

    assign bus.CMD_READY = state == IDLE;
    // this PREADY=0 edge is the TIMEOUT_CYCLES-th one; PREADY=1 is checked first so completion wins
    assign expire = TIMEOUT_CYCLES != 0 && wait_cnt == TLAST;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            bus.PSELx       <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.PWRITE      <= 1'b0;
            bus.PADDR       <= '0;
            bus.PWDATA      <= '0;
            bus.RSP_VALID   <= 1'b0;
            bus.RSP_RDATA   <= '0;
            bus.RSP_ERR     <= 1'b0;
            bus.RSP_TIMEOUT <= 1'b0;
            bus.ERR_COUNT   <= '0;
        end else begin
            state           <= state_n;
            wait_cnt        <= wait_cnt_n;
            bus.PSELx       <= psel_n;
            bus.PENABLE     <= penable_n;
            bus.PWRITE      <= pwrite_n;
            bus.PADDR       <= paddr_n;
            bus.PWDATA      <= pwdata_n;
            bus.RSP_VALID   <= rsp_valid_n;
            bus.RSP_RDATA   <= rsp_rdata_n;
            bus.RSP_ERR     <= rsp_err_n;
            bus.RSP_TIMEOUT <= rsp_timeout_n;
            bus.ERR_COUNT   <= err_count_n;
        end
    end

    always_comb begin
        state_n       = state;
        wait_cnt_n    = wait_cnt;
        psel_n        = bus.PSELx;
        penable_n     = bus.PENABLE;
        pwrite_n      = bus.PWRITE;
        paddr_n       = bus.PADDR;
        pwdata_n      = bus.PWDATA;
        rsp_valid_n   = bus.RSP_VALID;
        rsp_rdata_n   = bus.RSP_RDATA;
        rsp_err_n     = bus.RSP_ERR;
        rsp_timeout_n = bus.RSP_TIMEOUT;
        err_hit       = 1'b0;
        case (state)
            IDLE: if (bus.CMD_VALID) begin
                state_n  = SETUP;
                psel_n   = 1'b1;
                pwrite_n = bus.CMD_WRITE;
                paddr_n  = bus.CMD_ADDR;
                pwdata_n = bus.CMD_WDATA;
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
            end
            ACCESS: if (bus.PREADY) begin
                state_n       = RESP;
                psel_n        = 1'b0;
                penable_n     = 1'b0;
                rsp_valid_n   = 1'b1;
                rsp_err_n     = bus.PSLVERR;
                rsp_timeout_n = 1'b0;
                // select rather than mask so an X on PRDATA during a write never reaches RSP_RDATA
                rsp_rdata_n   = bus.PWRITE ? '0 : bus.PRDATA;
                err_hit       = bus.PSLVERR;
            end else if (expire) begin
                state_n       = RESP;
                wait_cnt_n    = wait_cnt + 1'b1;
                psel_n        = 1'b0;
                penable_n     = 1'b0;
                rsp_valid_n   = 1'b1;
                rsp_err_n     = 1'b0;
                rsp_timeout_n = 1'b1;
                rsp_rdata_n   = '0;
                err_hit       = 1'b1;
            end else if (TIMEOUT_CYCLES != 0) begin
                wait_cnt_n = wait_cnt + 1'b1;
            end
            RESP: if (bus.RSP_READY) begin
                state_n     = IDLE;
                rsp_valid_n = 1'b0;
                wait_cnt_n  = '0;
            end
            default: state_n = IDLE;
        endcase
        err_count_n = (err_hit && !(&bus.ERR_COUNT)) ? bus.ERR_COUNT + 1'b1 : bus.ERR_COUNT;
    end
endmodule
